nrisc_call_stack: RTL and testbench
===================================

// Module: nrisc_call_stack
// PURPOSE
//  Hardware return-address stack; the responder to the CPU's 2-bit STACK ctrl bus (CALL=push, RET/RETI=pop).
//  Stores {ULA flags, return PC} per entry. Presents the top-of-stack to the PC mux for RET/RETI and the saved flags for RETI.
//  Sits between the CPU control unit and the PC block; single clock domain.
// PARAMETERS
//  DATA_W   16  width of stored return address
//  FLAG_W   3   width of saved ULA flags {C,Z,M}
//  DEPTH    16  number of entries, power of 2, >=2
//  PTR_W    (localparam) $clog2(DEPTH)+1; stack pointer/count width
// PORTS
//  clk                 in   1        main clock, all state updates on posedge
//  rst                 in   1        synchronous, active-high reset
//  STACK_ctrl          in   2        command: 00 NOP, 01 PUSH, 10 POP, 11 CLEAR
//  STACK_valid         in   1        command qualifier; ctrl is sampled only when high
//  STACK_push_addr     in   DATA_W   return address to push (PC+1 from PC block)
//  STACK_push_flags    in   FLAG_W   ULA flags to push with the address
//  STACK_top_addr      out  DATA_W   address at top of stack; 0 when empty
//  STACK_top_flags     out  FLAG_W   flags at top of stack; 0 when empty
//  STACK_count         out  PTR_W    number of valid entries, 0..DEPTH
//  STACK_empty         out  1        count==0
//  STACK_full          out  1        count==DEPTH
//  STACK_overflow      out  1        sticky: PUSH attempted while full
//  STACK_underflow     out  1        sticky: POP attempted while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): count=0, top_addr=0, top_flags=0, overflow=0, underflow=0; empty=1, full=0.
//    RAM contents are not cleared. Reset has priority over any command in the same cycle.
//  - A command executes exactly once per cycle in which STACK_valid=1; valid=0 -> no state change regardless of ctrl.
//    CPU holds ctrl stable; repeated valid cycles repeat the op.
//  - PUSH, not full: mem[count]<={flags,addr}; count+=1; top_* <= pushed values at the same edge (1-cycle latency).
//  - PUSH, full: no write, count unchanged, top unchanged, overflow<=1.
//  - POP, count>=2: count-=1; top_* <= mem[count-2] (registered at the same edge).
//  - POP, count==1: count<=0; top_* <= 0.
//  - POP, empty: no change to count/top, underflow<=1.
//  - CLEAR: count<=0, top_*<=0, overflow<=0, underflow<=0.
//  - NOP: no state change.
//  - empty/full are combinational decodes of count; top_* are registers.
//  - Sticky flags clear only on rst or CLEAR.
//  - Count arithmetic is PTR_W wide, never wraps: saturates via the full/empty guards above.
//  - Outputs on the cycle after a command reflect the post-command state; no combinational path from ctrl to outputs.
// STRUCTURE
//  - Shared package nrisc_pkg: STACK_NOP=2'b00, STACK_PUSH=2'b01, STACK_POP=2'b10, STACK_CLEAR=2'b11;
//    NRISC_DATA_W=16, NRISC_FLAG_W=3 (also used by CPU control unit and PC block).
//  - Sub-module nrisc_stack_ram: DEPTH x (FLAG_W+DATA_W), one sync write port, one async read port (index count-2).
//  - Top level holds the pointer/count, top registers, sticky flags and command decode.
// TESTING
//  1. rst, then PUSH 0x0010/f=3'b001, 0x0020/f=3'b010, 0x0030/f=3'b100
//     -> count=3, top=0x0030/100; POP x3 -> top 0x0020, 0x0010, then 0/000, empty=1.
//  2. DEPTH pushes of 0x0100+i, one more PUSH 0xBEEF
//     -> full=1, overflow=1, count=DEPTH, top=0x0100+DEPTH-1 (0xBEEF not stored).
//  3. From empty, POP -> underflow=1, count=0, top=0; then PUSH 0x0042
//     -> count=1, top=0x0042, underflow still 1; CLEAR -> all flags 0, empty=1.
//  4. STACK_ctrl=PUSH held 4 cycles with valid high only in cycle 2
//     -> count=1 after cycle 2, unchanged afterwards.
//  5. Push 2 entries, assert rst in the same cycle as a PUSH of 0x0077
//     -> next cycle count=0, top=0, flags 0; subsequent POP sets underflow.
//  6. Interleaved PUSH 0xA/POP/PUSH 0xB/PUSH 0xC/POP
//     -> top sequence 0xA, 0, 0xB, 0xC, 0xB; count 1,0,1,2,1.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared NRISC definitions: STACK command encoding and datapath widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nrisc_pkg;

  // Encoding of the 2-bit STACK ctrl bus driven by the CPU control unit
  typedef enum logic [1:0] {
    STACK_NOP   = 2'b00,
    STACK_PUSH  = 2'b01,
    STACK_POP   = 2'b10,
    STACK_CLEAR = 2'b11
  } stack_cmd_e;

  localparam int NRISC_DATA_W = 16;
  localparam int NRISC_FLAG_W = 3;

endpackage

// File: rtl/nrisc_stack_ram.sv
// Storage array for the return-address stack: one sync write port, one async read port.
// Latency: write lands at the clock edge; read data is combinational from the index.
// Backpressure: none; the caller guards writes against a full stack.
module nrisc_stack_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 19,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write one entry per push; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  // Asynchronous read of the entry that becomes top after a pop
  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/nrisc_call_stack.sv
// Hardware return-address stack holding {flags, return PC}, driven by the CPU STACK ctrl bus.
// Latency: one cycle; outputs show the post-command state the cycle after a valid command.
// Backpressure: none; push when full / pop when empty are dropped and latched as sticky errors.
module nrisc_call_stack
  import nrisc_pkg::*;
#(
  parameter int  DATA_W = NRISC_DATA_W,
  parameter int  FLAG_W = NRISC_FLAG_W,
  parameter int  DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        STACK_ctrl,
  input  logic              STACK_valid,
  input  logic [DATA_W-1:0] STACK_push_addr,
  input  logic [FLAG_W-1:0] STACK_push_flags,
  output logic [DATA_W-1:0] STACK_top_addr,
  output logic [FLAG_W-1:0] STACK_top_flags,
  output logic [PTR_W-1:0]  STACK_count,
  output logic              STACK_empty,
  output logic              STACK_full,
  output logic              STACK_overflow,
  output logic              STACK_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = FLAG_W + DATA_W;

  logic [PTR_W-1:0]  count_q,     count_d;
  logic [DATA_W-1:0] top_addr_q,  top_addr_d;
  logic [FLAG_W-1:0] top_flags_q, top_flags_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;

  logic              ram_wr_en;
  logic [AW-1:0]     ram_wr_idx;
  logic [AW-1:0]     ram_rd_idx;
  logic [EW-1:0]     ram_rd_dat;
  logic              is_empty;
  logic              is_full;

  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == PTR_W'(DEPTH));
  // Next free slot; only used when not full, so it always fits in AW bits
  assign ram_wr_idx = AW'(count_q);
  // Entry just below the current top, i.e. the new top after a pop
  assign ram_rd_idx = AW'(count_q - PTR_W'(2));

  nrisc_stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_wr_en),
    .wr_idx (ram_wr_idx),
    .wr_dat ({STACK_push_flags, STACK_push_addr}),
    .rd_idx (ram_rd_idx),
    .rd_dat (ram_rd_dat)
  );

  // Command decode: next pointer, top registers, sticky errors and RAM write enable
  always_comb begin
    count_d     = count_q;
    top_addr_d  = top_addr_q;
    top_flags_d = top_flags_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    ram_wr_en   = 1'b0;
    if (STACK_valid) begin
      case (stack_cmd_e'(STACK_ctrl))
        STACK_PUSH: begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            ram_wr_en   = 1'b1;
            count_d     = count_q + PTR_W'(1);
            top_addr_d  = STACK_push_addr;
            top_flags_d = STACK_push_flags;
          end
        end
        STACK_POP: begin
          if (is_empty) begin
            underflow_d = 1'b1;
          end else if (count_q == PTR_W'(1)) begin
            count_d     = '0;
            top_addr_d  = '0;
            top_flags_d = '0;
          end else begin
            count_d     = count_q - PTR_W'(1);
            top_addr_d  = ram_rd_dat[DATA_W-1:0];
            top_flags_d = ram_rd_dat[EW-1:DATA_W];
          end
        end
        STACK_CLEAR: begin
          count_d     = '0;
          top_addr_d  = '0;
          top_flags_d = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers; reset wins over any command in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      top_addr_q  <= '0;
      top_flags_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      top_addr_q  <= top_addr_d;
      top_flags_q <= top_flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign STACK_top_addr  = top_addr_q;
  assign STACK_top_flags = top_flags_q;
  assign STACK_count     = count_q;
  assign STACK_empty     = is_empty;
  assign STACK_full      = is_full;
  assign STACK_overflow  = overflow_q;
  assign STACK_underflow = underflow_q;

endmodule

// File: tb/tb_nrisc_call_stack.sv
// Self-checking bench for nrisc_call_stack: directed scenarios plus a random command stream.
// Latency: inputs driven on negedge, checked on the following negedge.
// Backpressure: n/a.
module tb_nrisc_call_stack;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH) + 1;

  localparam logic [1:0] C_NOP   = 2'b00;
  localparam logic [1:0] C_PUSH  = 2'b01;
  localparam logic [1:0] C_POP   = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        STACK_ctrl;
  logic              STACK_valid;
  logic [DATA_W-1:0] STACK_push_addr;
  logic [FLAG_W-1:0] STACK_push_flags;
  logic [DATA_W-1:0] STACK_top_addr;
  logic [FLAG_W-1:0] STACK_top_flags;
  logic [PTR_W-1:0]  STACK_count;
  logic              STACK_empty;
  logic              STACK_full;
  logic              STACK_overflow;
  logic              STACK_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {flags, addr}, back = top of stack
  logic [FLAG_W+DATA_W-1:0] model_q[$];
  logic                     m_ovf;
  logic                     m_unf;

  always #5 clk = ~clk;

  nrisc_call_stack #(
    .DATA_W (DATA_W),
    .FLAG_W (FLAG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .STACK_ctrl       (STACK_ctrl),
    .STACK_valid      (STACK_valid),
    .STACK_push_addr  (STACK_push_addr),
    .STACK_push_flags (STACK_push_flags),
    .STACK_top_addr   (STACK_top_addr),
    .STACK_top_flags  (STACK_top_flags),
    .STACK_count      (STACK_count),
    .STACK_empty      (STACK_empty),
    .STACK_full       (STACK_full),
    .STACK_overflow   (STACK_overflow),
    .STACK_underflow  (STACK_underflow)
  );

  // One clock of stimulus; the model follows the stated stack rules
  task automatic step(input logic [1:0] c, input logic v, input logic [DATA_W-1:0] a,
                      input logic [FLAG_W-1:0] f, input logic r);
    STACK_ctrl       = c;
    STACK_valid      = v;
    STACK_push_addr  = a;
    STACK_push_flags = f;
    rst              = r;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (v) begin
      case (c)
        C_PUSH:  if (model_q.size() < DEPTH) model_q.push_back({f, a}); else m_ovf = 1'b1;
        C_POP:   if (model_q.size() > 0) void'(model_q.pop_back()); else m_unf = 1'b1;
        C_CLEAR: begin model_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
        default: ;
      endcase
    end
    @(negedge clk);
    STACK_valid = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic test_reset();
    step(C_NOP, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if (STACK_count !== '0 || STACK_top_addr !== '0 || STACK_top_flags !== '0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d top=%h/%b required 0/0000/000", STACK_count, STACK_top_addr, STACK_top_flags);
    end
    n_checks++;
    if ({STACK_empty, STACK_full, STACK_overflow, STACK_underflow} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: e/f/o/u=%b required 1000", {STACK_empty, STACK_full, STACK_overflow, STACK_underflow});
    end
  endtask

  task automatic test_push_pop();
    logic [DATA_W-1:0] pop_addr [3];
    logic [FLAG_W-1:0] pop_flag [3];
    pop_addr = '{16'h0020, 16'h0010, 16'h0000};
    pop_flag = '{3'b010, 3'b001, 3'b000};
    step(C_PUSH, 1'b1, 16'h0010, 3'b001, 1'b0);
    step(C_PUSH, 1'b1, 16'h0020, 3'b010, 1'b0);
    step(C_PUSH, 1'b1, 16'h0030, 3'b100, 1'b0);
    n_checks++;
    if (STACK_count !== PTR_W'(3) || STACK_top_addr !== 16'h0030 || STACK_top_flags !== 3'b100) begin
      n_fail++;
      $display("FAIL push3: count=%0d top=%h/%b required 3/0030/100", STACK_count, STACK_top_addr, STACK_top_flags);
    end
    for (int i = 0; i < 3; i++) begin
      step(C_POP, 1'b1, '0, '0, 1'b0);
      n_checks++;
      if (STACK_top_addr !== pop_addr[i] || STACK_top_flags !== pop_flag[i] || STACK_count !== PTR_W'(2 - i)) begin
        n_fail++;
        $display("FAIL pop_%0d: top=%h/%b count=%0d required %h/%b/%0d", i, STACK_top_addr, STACK_top_flags,
                 STACK_count, pop_addr[i], pop_flag[i], 2 - i);
      end
    end
    n_checks++;
    if (STACK_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_empty: empty=%b required 1", STACK_empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(C_PUSH, 1'b1, 16'h0100 + DATA_W'(i), FLAG_W'(i), 1'b0);
    n_checks++;
    if (STACK_full !== 1'b1 || STACK_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: full=%b ovf=%b required 1/0", STACK_full, STACK_overflow);
    end
    step(C_PUSH, 1'b1, 16'hBEEF, 3'b111, 1'b0);
    n_checks++;
    if (STACK_full !== 1'b1 || STACK_overflow !== 1'b1 || STACK_count !== PTR_W'(DEPTH) ||
        STACK_top_addr !== 16'h010F || STACK_top_flags !== 3'b111) begin
      n_fail++;
      $display("FAIL overflow: full=%b ovf=%b count=%0d top=%h/%b required 1/1/%0d/010f/111",
               STACK_full, STACK_overflow, STACK_count, STACK_top_addr, STACK_top_flags, DEPTH);
    end
    step(C_POP, 1'b1, '0, '0, 1'b0);
    n_checks++;
    if (STACK_top_addr !== 16'h010E || STACK_top_flags !== 3'b110 || STACK_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_after_full: top=%h/%b ovf=%b required 010e/110/1", STACK_top_addr, STACK_top_flags, STACK_overflow);
    end
  endtask

  task automatic test_underflow();
    step(C_CLEAR, 1'b1, '0, '0, 1'b0);
    step(C_POP, 1'b1, '0, '0, 1'b0);
    n_checks++;
    if (STACK_underflow !== 1'b1 || STACK_count !== '0 || STACK_top_addr !== '0 || STACK_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow: unf=%b count=%0d top=%h ovf=%b required 1/0/0000/0",
               STACK_underflow, STACK_count, STACK_top_addr, STACK_overflow);
    end
    step(C_PUSH, 1'b1, 16'h0042, 3'b011, 1'b0);
    n_checks++;
    if (STACK_count !== PTR_W'(1) || STACK_top_addr !== 16'h0042 || STACK_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_sticky: count=%0d top=%h unf=%b required 1/0042/1", STACK_count, STACK_top_addr, STACK_underflow);
    end
    step(C_CLEAR, 1'b1, '0, '0, 1'b0);
    n_checks++;
    if ({STACK_empty, STACK_full, STACK_overflow, STACK_underflow} !== 4'b1000 || STACK_top_addr !== '0) begin
      n_fail++;
      $display("FAIL clear: e/f/o/u=%b top=%h required 1000/0000",
               {STACK_empty, STACK_full, STACK_overflow, STACK_underflow}, STACK_top_addr);
    end
  endtask

  task automatic test_valid_qual();
    logic [PTR_W-1:0] exp_cnt [4];
    exp_cnt = '{PTR_W'(0), PTR_W'(1), PTR_W'(1), PTR_W'(1)};
    for (int i = 0; i < 4; i++) begin
      step(C_PUSH, (i == 1), 16'h0055, 3'b101, 1'b0);
      n_checks++;
      if (STACK_count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL valid_qual_%0d: count=%0d required %0d", i, STACK_count, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    step(C_CLEAR, 1'b1, '0, '0, 1'b0);
    step(C_PUSH, 1'b1, 16'h0001, 3'b001, 1'b0);
    step(C_PUSH, 1'b1, 16'h0002, 3'b010, 1'b0);
    step(C_PUSH, 1'b1, 16'h0077, 3'b111, 1'b1);
    n_checks++;
    if (STACK_count !== '0 || STACK_top_addr !== '0 || STACK_top_flags !== '0 ||
        STACK_overflow !== 1'b0 || STACK_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_priority: count=%0d top=%h/%b o/u=%b%b required 0/0000/000/00",
               STACK_count, STACK_top_addr, STACK_top_flags, STACK_overflow, STACK_underflow);
    end
    step(C_POP, 1'b1, '0, '0, 1'b0);
    n_checks++;
    if (STACK_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_then_pop: unf=%b required 1", STACK_underflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]        ops  [5];
    logic [DATA_W-1:0] data [5];
    logic [DATA_W-1:0] tops [5];
    logic [PTR_W-1:0]  cnts [5];
    ops  = '{C_PUSH, C_POP, C_PUSH, C_PUSH, C_POP};
    data = '{16'h000A, 16'h0000, 16'h000B, 16'h000C, 16'h0000};
    tops = '{16'h000A, 16'h0000, 16'h000B, 16'h000C, 16'h000B};
    cnts = '{PTR_W'(1), PTR_W'(0), PTR_W'(1), PTR_W'(2), PTR_W'(1)};
    step(C_CLEAR, 1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(ops[i], 1'b1, data[i], 3'b010, 1'b0);
      n_checks++;
      if (STACK_top_addr !== tops[i] || STACK_count !== cnts[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: top=%h count=%0d required %h/%0d", i, STACK_top_addr, STACK_count, tops[i], cnts[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [FLAG_W+DATA_W-1:0] exp_top;
    step(C_NOP, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [1:0] c;
      int         sel;
      sel = $urandom_range(0, 99);
      // Bias toward push/pop so both boundaries get exercised
      c = (sel < 48) ? C_PUSH : (sel < 92) ? C_POP : (sel < 96) ? C_NOP : C_CLEAR;
      step(c, ($urandom_range(0, 7) != 0), DATA_W'($urandom), FLAG_W'($urandom), ($urandom_range(0, 199) == 0));
      exp_top = (model_q.size() > 0) ? model_q[model_q.size() - 1] : '0;
      n_checks++;
      if (STACK_count !== PTR_W'(model_q.size()) || {STACK_top_flags, STACK_top_addr} !== exp_top) begin
        n_fail++;
        $display("FAIL rand_state_%0d: count=%0d top=%h required %0d/%h", i, STACK_count,
                 {STACK_top_flags, STACK_top_addr}, model_q.size(), exp_top);
      end
      n_checks++;
      if ({STACK_empty, STACK_full, STACK_overflow, STACK_underflow} !==
          {model_q.size() == 0, model_q.size() == DEPTH, m_ovf, m_unf}) begin
        n_fail++;
        $display("FAIL rand_flags_%0d: e/f/o/u=%b required %b", i,
                 {STACK_empty, STACK_full, STACK_overflow, STACK_underflow},
                 {model_q.size() == 0, model_q.size() == DEPTH, m_ovf, m_unf});
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    STACK_ctrl       = C_NOP;
    STACK_valid      = 1'b0;
    STACK_push_addr  = '0;
    STACK_push_flags = '0;
    m_ovf            = 1'b0;
    m_unf            = 1'b0;
    @(negedge clk);
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_valid_qual();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
